// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: round-robin between two pixel producers,
// plus a full-frame clear sweep that locks both producers out.
module fb_write_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 15,
    parameter int unsigned FB_DEPTH    = 19200,
    parameter logic        CLEAR_PIXEL = 1'b0
) (
    input  logic                  clk_25,
    input  logic                  reset,
    input  logic                  clear_start,
    output logic                  clear_busy,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic                  pix0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic                  pix1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic                  pixel,
    output logic                  oob_err
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(FB_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_WIDE = (ADDR_WIDTH + 1)'(FB_DEPTH);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_ptr;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_pix;
    logic                    r_oob;

    logic                    w_gnt0;
    logic                    w_gnt1;
    logic                    w_clear_load;
    logic [ADDR_WIDTH-1:0]   w_gnt_addr;
    logic                    w_gnt_pix;
    logic                    w_in_range;

    // Next state and combinational grants; clear_start beats any request.
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        w_clear_load = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_ARB: begin
                    if (clear_start) begin
                        w_state_nxt  = ST_CLEAR;
                        w_clear_load = 1'b1;
                    end else if (req0 && (!req1 || !r_ptr)) begin
                        w_gnt0 = 1'b1;
                    end else if (req1) begin
                        w_gnt1 = 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (r_cnt == LAST_ADDR) begin
                        w_state_nxt = ST_ARB;
                    end
                end
                default: w_state_nxt = ST_ARB;
            endcase
        end
    end

    assign w_gnt_addr = w_gnt0 ? addr0 : addr1;
    assign w_gnt_pix  = w_gnt0 ? pix0  : pix1;
    // Widened compare so FB_DEPTH == 2**ADDR_WIDTH still works.
    assign w_in_range = ({1'b0, w_gnt_addr} < DEPTH_WIDE);

    // State, pointer, clear counter and registered write port.
    always_ff @(posedge clk_25) begin
        if (reset) begin
            r_state <= ST_ARB;
            r_ptr   <= 1'b0;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_pix   <= 1'b0;
            r_oob   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= 1'b0;
            r_oob   <= 1'b0;
            if (r_state == ST_CLEAR) begin
                r_we   <= 1'b1;
                r_addr <= r_cnt;
                r_pix  <= CLEAR_PIXEL;
                if (r_cnt != LAST_ADDR) begin
                    r_cnt <= r_cnt + ADDR_WIDTH'(1);
                end
            end else if (w_clear_load) begin
                r_cnt <= '0;
            end else if (w_gnt0 || w_gnt1) begin
                r_ptr <= w_gnt0;
                if (w_in_range) begin
                    r_we   <= 1'b1;
                    r_addr <= w_gnt_addr;
                    r_pix  <= w_gnt_pix;
                end else begin
                    r_oob <= 1'b1;
                end
            end
        end
    end

    assign gnt0       = w_gnt0;
    assign gnt1       = w_gnt1;
    assign clear_busy = (r_state == ST_CLEAR);
    assign we         = r_we;
    assign write_addr = r_addr;
    assign pixel      = r_pix;
    assign oob_err    = r_oob;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: vector table plus clear/reset sequences,
// with expected write-port values queued per cycle and checked after the edge.
module tb_fb_write_arbiter;

    localparam int unsigned AW    = 15;
    localparam int unsigned DEPTH = 19200;

    logic          clk_25 = 1'b0;
    logic          reset, clear_start, clear_busy;
    logic          req0, pix0, req1, pix1;
    logic [AW-1:0] addr0, addr1, write_addr;
    logic          gnt0, gnt1, we, pixel, oob_err;

    fb_write_arbiter #(.ADDR_WIDTH(AW), .FB_DEPTH(DEPTH), .CLEAR_PIXEL(1'b0)) dut (
        .clk_25(clk_25), .reset(reset), .clear_start(clear_start), .clear_busy(clear_busy),
        .req0(req0), .addr0(addr0), .pix0(pix0),
        .req1(req1), .addr1(addr1), .pix1(pix1),
        .gnt0(gnt0), .gnt1(gnt1), .we(we), .write_addr(write_addr),
        .pixel(pixel), .oob_err(oob_err)
    );

    always #5 clk_25 = ~clk_25;

    typedef struct {
        logic          rst;
        logic          cs;
        logic          r0;
        logic [AW-1:0] a0;
        logic          p0;
        logic          r1;
        logic [AW-1:0] a1;
        logic          p1;
        logic          g0;     // expected grants this cycle
        logic          g1;
        logic          busy;   // expected clear_busy after the edge
        logic          cw;     // expected clear write at address ca after the edge
        logic [AW-1:0] ca;
    } vec_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic          pix;
        logic          oob;
        logic          busy;
    } exp_t;

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    logic [AW-1:0] last_addr = '0;
    logic          last_pix  = 1'b0;
    vec_t          tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic cs,
                                input logic r0, input int a0, input logic p0,
                                input logic r1, input int a1, input logic p1,
                                input logic g0, input logic g1, input logic busy,
                                input logic cw, input int ca);
        vec_t v;
        v.rst = rst; v.cs = cs;
        v.r0 = r0; v.a0 = AW'(a0); v.p0 = p0;
        v.r1 = r1; v.a1 = AW'(a1); v.p1 = p1;
        v.g0 = g0; v.g1 = g1; v.busy = busy; v.cw = cw; v.ca = AW'(ca);
        return v;
    endfunction

    // One cycle: drive at negedge, check grants, queue expectation, check after posedge.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        @(negedge clk_25);
        reset = v.rst; clear_start = v.cs;
        req0 = v.r0; addr0 = v.a0; pix0 = v.p0;
        req1 = v.r1; addr1 = v.a1; pix1 = v.p1;
        #1;
        chk({tag, ".gnt0"}, int'(gnt0), int'(v.g0));
        chk({tag, ".gnt1"}, int'(gnt1), int'(v.g1));
        e.busy = v.busy;
        e.oob  = 1'b0;
        e.we   = 1'b0;
        if (v.rst) begin
            last_addr = '0;
            last_pix  = 1'b0;
            e.busy    = 1'b0;
        end else if (v.cw) begin
            e.we = 1'b1; last_addr = v.ca; last_pix = 1'b0;
        end else if (v.g0 || v.g1) begin
            if (int'(v.g0 ? v.a0 : v.a1) < DEPTH) begin
                e.we = 1'b1;
                last_addr = v.g0 ? v.a0 : v.a1;
                last_pix  = v.g0 ? v.p0 : v.p1;
            end else begin
                e.oob = 1'b1;
            end
        end
        e.addr = last_addr;
        e.pix  = last_pix;
        sb.push_back(e);
        @(posedge clk_25);
        #1;
        got = sb.pop_front();
        chk({tag, ".we"},         int'(we),         int'(got.we));
        chk({tag, ".write_addr"}, int'(write_addr), int'(got.addr));
        chk({tag, ".pixel"},      int'(pixel),      int'(got.pix));
        chk({tag, ".oob_err"},    int'(oob_err),    int'(got.oob));
        chk({tag, ".clear_busy"}, int'(clear_busy), int'(got.busy));
    endtask

    initial begin
        reset = 1'b1; clear_start = 1'b0;
        req0 = 1'b0; addr0 = '0; pix0 = 1'b0;
        req1 = 1'b0; addr1 = '0; pix1 = 1'b0;

        //            rst cs r0 a0     p0 r1 a1     p1 g0 g1 bsy cw ca
        tbl.push_back(mk(1, 0, 1, 5,     1, 0, 0,     0, 0, 0, 0, 0, 0));  // reset, req0 held
        tbl.push_back(mk(1, 0, 1, 5,     1, 0, 0,     0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,     1, 0, 0,     0, 1, 0, 0, 0, 0));  // stream 0,1,2
        tbl.push_back(mk(0, 0, 1, 1,     1, 0, 0,     0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 2,     1, 0, 0,     0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 2,     1, 0, 0,     0, 0, 0, 0, 0, 0));  // idle: hold
        tbl.push_back(mk(1, 0, 0, 0,     0, 0, 0,     0, 0, 0, 0, 0, 0));  // reset
        tbl.push_back(mk(0, 0, 1, 10,    1, 1, 20,    0, 1, 0, 0, 0, 0));  // contention 0,1,0,1
        tbl.push_back(mk(0, 0, 1, 10,    1, 1, 20,    0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 10,    1, 1, 20,    0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 10,    1, 1, 20,    0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     0, 1, 19200, 1, 0, 1, 0, 0, 0));  // oob, ptr -> 0
        tbl.push_back(mk(0, 0, 1, 30,    1, 1, 40,    0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,     0, 1, 19199, 1, 0, 1, 0, 0, 0));  // last valid addr
        tbl.push_back(mk(0, 0, 1, 32767, 0, 1, 7,     1, 1, 0, 0, 0, 0));  // max addr oob
        tbl.push_back(mk(0, 0, 1, 3,     0, 1, 7,     1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 100,   1, 1, 9,     0, 0, 0, 1, 0, 0));  // clear beats req

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // Full sweep with req0 held; second clear_start mid-sweep must be ignored.
        for (int i = 0; i < int'(DEPTH); i++) begin
            step(mk(0, (i == 5000) ? 1'b1 : 1'b0, 1, 100, 1, 0, 0, 0,
                    0, 0, (i != int'(DEPTH) - 1) ? 1'b1 : 1'b0, 1, i),
                 $sformatf("clr%0d", i));
        end
        step(mk(0, 0, 1, 100, 1, 0, 0, 0, 1, 0, 0, 0, 0), "post_clr_gnt");

        // Reset at sweep address 500 abandons the clear.
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "rclr_start");
        for (int i = 0; i < 500; i++) begin
            step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, i), $sformatf("rclr%0d", i));
        end
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rclr_reset");
        for (int i = 0; i < 4; i++) begin
            step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), $sformatf("rclr_idle%0d", i));
        end
        step(mk(0, 0, 1, 11, 1, 1, 22, 1, 1, 0, 0, 0, 0), "resume0");
        step(mk(0, 0, 1, 11, 1, 1, 22, 1, 0, 1, 0, 0, 0), "resume1");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Arbitrates the single QQVGA framebuffer write port (`we`, `write_addr`, `pixel`) between two pixel producers: the pattern filler (requester 0) and a second draw source (requester 1). It also sequences a full-frame clear on command, sweeping every framebuffer address with a fixed pixel value while holding both requesters off. It sits between the producers and the framebuffer RAM write port in the `clk_25` domain, and drives the same port the filler drives directly today.

## Interface

- `ADDR_WIDTH`, 15: framebuffer address width.
- `FB_DEPTH`, 19200: valid pixel count (160x120). Must be ≤ 2^ADDR_WIDTH.
- `CLEAR_PIXEL`, 1'b0: pixel value written during clear.

- `clk_25`  in  1  pixel clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `clear_start`  in  1  single-cycle pulse; starts a full-frame clear.
- `clear_busy`  out  1  high while the clear sweep is in progress.
- `req0` / `req1`  in  1  write request from requester 0 / 1.
- `addr0` / `addr1`  in  ADDR_WIDTH  requested write address.
- `pix0` / `pix1`  in  1  requested pixel value.
- `gnt0` / `gnt1`  out  1  combinational grant; the request is accepted in this cycle.
- `we`  out  1  framebuffer write enable (registered).
- `write_addr`  out  ADDR_WIDTH  framebuffer write address (registered).
- `pixel`  out  1  framebuffer write data (registered).
- `oob_err`  out  1  one-cycle pulse when a granted address is ≥ FB_DEPTH.

## Operation

- FSM with two states: ARB (after reset) and CLEAR.
- **Handshake:**
  - A requester holds `req`, `addr` and `pix` stable until it sees `gnt` high.
  - One grant equals one write.
  - A requester may keep `req` high to request back-to-back writes.
- **ARB state:**
  - If `clear_start` is high, go to CLEAR: load clear counter = 0, set `clear_busy` = 1, issue no grant this cycle.
  - Otherwise, round-robin between the requesters:
    - If only one requester is requesting, it is granted.
    - If both are requesting, the one selected by the priority pointer is granted.
  - After any grant, the pointer moves to the other requester.
  - At most one `gnt` is high per cycle.
- **Granted write, address in range** (`addr` < FB_DEPTH, unsigned compare): next cycle `we` = 1, `write_addr` = `addr`, `pixel` = `pix`.
- **Granted write, address out of range:**
  - The write is dropped: next cycle `we` = 0 and `oob_err` = 1.
  - The grant still counts, and the pointer still flips.
- **No grant:** next cycle `we` = 0. `write_addr` and `pixel` hold their previous values.
- **CLEAR state:**
  - `gnt0` = `gnt1` = 0.
  - Each cycle the block writes `counter` with CLEAR_PIXEL, then increments the counter.
  - On the cycle the counter equals FB_DEPTH-1, that address is written, the FSM returns to ARB and `clear_busy` drops.
  - `clear_start` during CLEAR is ignored; it does not restart the sweep.
- **Reset (any state, including mid-clear):**
  - FSM goes to ARB and the pointer goes to requester 0.
  - `clear_busy`, `we`, `oob_err`, `gnt0`, `gnt1` = 0; `write_addr` = 0; `pixel` = 0.
  - An in-progress clear is abandoned with no further writes.
  - Grants are forced to 0 while `reset` is high.

## Timing

- **Grant to write:** a grant in cycle c gives `we` high in cycle c+1. Sustained throughput is one write per cycle.
- **Both requesters continuously requesting:** grants alternate every cycle, starting with the pointer's requester.
- **Clear:**
  - `clear_start` is sampled at edge E0.
  - `clear_busy` is high from E0 until E19200, exactly FB_DEPTH cycles.
  - `we` is high for FB_DEPTH consecutive cycles starting one cycle after `clear_busy` rises. Addresses run 0 to FB_DEPTH-1 in order.
  - The first grant can occur in the cycle after `clear_busy` falls. Its write is then contiguous with the final clear write.
- **`clear_start` and `req` in the same ARB cycle:** clear wins and no grant is issued.
- **Counter width:** ADDR_WIDTH bits. It never wraps, because it stops at FB_DEPTH-1.

## Test plan

- **Reset:** assert `reset` for 2 cycles while `req0` = 1 → all outputs 0 and `gnt0` = 0 during reset. On release, `gnt0` = 1 in the first cycle.
- **Single requester stream:** `req0` held with `addr0` = 0, 1, 2 and `pix0` = 1 → `we` = 1 on three consecutive cycles with `write_addr` = 0, 1, 2, each one cycle after its grant.
- **Contention:** `req0` and `req1` both held for 4 cycles after reset → grant sequence 0, 1, 0, 1. `write_addr` alternates between `addr0` and `addr1`.
- **Out of range:** `req1` with `addr1` = 19200 → `gnt1` = 1, then next cycle `oob_err` = 1 and `we` = 0. The next contended grant goes to requester 0.
- **Full clear:** pulse `clear_start` with `req0` = 1 →
  - `gnt0` stays 0 for 19200 cycles;
  - 19200 writes of 0 to addresses 0..19199;
  - `clear_busy` falls, then `gnt0` = 1 on the next cycle.
  - A second `clear_start` mid-sweep does not lengthen the sweep.
- **Reset mid-clear:** assert `reset` at sweep address 500 → `we` = 0 and `clear_busy` = 0 on the next cycle. No writes follow, and normal arbitration resumes after release.
